// File: rtl/sound_pkg.sv
// Shared state encoding and per-source timing constants for the sound arbiter.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int unsigned MAX_SRC        = 4;
    localparam int unsigned DUR_IDX_W      = $clog2(MAX_SRC);
    localparam int unsigned REM_W          = 16;
    localparam int unsigned GAP_MS_DEFAULT = 20;

    localparam logic [REM_W-1:0] DUR_MS [MAX_SRC] = '{16'd50, 16'd150, 16'd500, 16'd1500};

    // Sources beyond the table reuse the longest entry so a duration is never zero.
    function automatic logic [REM_W-1:0] dur_ms(input int unsigned idx);
        logic [DUR_IDX_W-1:0] sel;
        sel = (idx < MAX_SRC) ? DUR_IDX_W'(idx) : DUR_IDX_W'(MAX_SRC - 1);
        return DUR_MS[sel];
    endfunction

endpackage

// File: rtl/ms_ticker.sv
// Millisecond strobe: free-running divider that can be realigned with a synchronous restart.
module ms_ticker #(
    parameter int unsigned CLK_FREQ_per_ms = 25_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic tick_c
);

    localparam int unsigned CNT_W = (CLK_FREQ_per_ms > 1) ? $clog2(CLK_FREQ_per_ms) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_FREQ_per_ms - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick_c = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (restart_i || tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sound_arbiter.sv
// Priority arbiter sharing one speaker among N_SRC melody generators, with preemption
// by higher-priority sources and a fixed silent gap between consecutive sounds.
module sound_arbiter
    import sound_pkg::*;
#(
    parameter int unsigned N_SRC           = 4,
    parameter int unsigned CLK_FREQ_per_ms = 25_000,
    parameter int unsigned GAP_MS          = GAP_MS_DEFAULT
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [N_SRC-1:0]                                req,
    input  logic [N_SRC-1:0]                                square_in,
    input  logic                                            mute,
    output logic [N_SRC-1:0]                                trig_n,
    output logic                                            audio_out,
    output logic                                            busy,
    output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0]    active_id
);

    localparam int unsigned ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    state_e             state_q;
    logic [N_SRC-1:0]   pending_q;
    logic [N_SRC-1:0]   pending_d;
    logic [N_SRC-1:0]   trig_n_q;
    logic [ID_W-1:0]    active_id_q;
    logic [REM_W-1:0]   remaining_q;
    logic               audio_q;
    logic               busy_q;

    logic [ID_W-1:0]    winner_c;
    logic [N_SRC-1:0]   win_trig_n_c;
    logic [N_SRC-1:0]   clr_c;
    logic               any_pending_c;
    logic               preempt_c;
    logic               last_ms_c;
    logic               restart_c;
    logic               tick_c;

    ms_ticker #(
        .CLK_FREQ_per_ms (CLK_FREQ_per_ms)
    ) u_ms_ticker (
        .clk       (clk),
        .reset     (reset),
        .restart_i (restart_c),
        .tick_c    (tick_c)
    );

    // Highest pending index wins; only registered flags take part.
    always_comb begin
        winner_c = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (pending_q[i]) begin
                winner_c = ID_W'(i);
            end
        end
    end

    always_comb begin
        win_trig_n_c           = '1;
        win_trig_n_c[winner_c] = 1'b0;
        clr_c                  = '0;
        if (state_q == START || state_q == PLAY) begin
            clr_c[active_id_q] = 1'b1;
        end
        // A new request beats the clear in the same cycle.
        pending_d     = (pending_q & ~clr_c) | req;
        any_pending_c = |pending_q;
        preempt_c     = any_pending_c && (winner_c > active_id_q);
        last_ms_c     = tick_c && (remaining_q <= REM_W'(1));
        restart_c     = (state_q == START);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            trig_n_q    <= '1;
            active_id_q <= '0;
            remaining_q <= '0;
            audio_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            trig_n_q  <= '1;
            audio_q   <= (state_q == PLAY) && !mute && square_in[active_id_q];

            case (state_q)
                IDLE: begin
                    if (any_pending_c) begin
                        state_q     <= START;
                        active_id_q <= winner_c;
                        trig_n_q    <= win_trig_n_c;
                        busy_q      <= 1'b1;
                    end
                end
                START: begin
                    state_q     <= PLAY;
                    remaining_q <= dur_ms(32'(active_id_q));
                end
                PLAY: begin
                    if (preempt_c) begin
                        state_q     <= START;
                        active_id_q <= winner_c;
                        trig_n_q    <= win_trig_n_c;
                    end else if (last_ms_c) begin
                        state_q     <= GAP;
                        remaining_q <= REM_W'(GAP_MS);
                    end else if (tick_c) begin
                        remaining_q <= remaining_q - REM_W'(1);
                    end
                end
                GAP: begin
                    // remaining_q doubles as the gap countdown.
                    if (last_ms_c) begin
                        if (any_pending_c) begin
                            state_q     <= START;
                            active_id_q <= winner_c;
                            trig_n_q    <= win_trig_n_c;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (tick_c) begin
                        remaining_q <= remaining_q - REM_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign trig_n    = trig_n_q;
    assign audio_out = audio_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter N_SRC, default 4: number of melody sources, index 0..N_SRC-1, higher index = higher priority.
REQ-002 Parameter CLK_FREQ_per_ms, default 25_000: clk cycles per millisecond.
REQ-003 Parameter GAP_MS, default 20: silent gap in ms between consecutive sounds.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  N_SRC  per-source play request, single-cycle pulse from game logic.
REQ-007 square_in  input  N_SRC  square_wave outputs of the N_SRC melody generators.
REQ-008 mute  input  1  level; forces audio silent, sequencing continues.
REQ-009 trig_n  output  N_SRC  active-low trigger to each melody generator's off input.
REQ-010 audio_out  output  1  speaker drive.
REQ-011 busy  output  1  high when state is not IDLE.
REQ-012 active_id  output  $clog2(N_SRC)  index of source currently owning the speaker.

Function
REQ-013 req bits SHALL set sticky pending flags; set wins over clear in the same cycle.
REQ-014 Arbitration SHALL use registered pending flags only (req visible one cycle after arrival); winner = highest set index.
REQ-015 FSM states SHALL be IDLE, START, PLAY, GAP.
REQ-016 IDLE: any pending -> START with active_id <= winner; none -> stay.
REQ-017 START: lasts exactly 1 cycle; trig_n[active_id] = 0, all other bits 1; clears pending[active_id]; loads remaining_ms <= DUR_MS[active_id]; restarts ms tick counter; -> PLAY.
REQ-018 PLAY: remaining_ms decrements on each ms tick; at tick with remaining_ms == 1 -> GAP.
REQ-019 PLAY: pending flag with index > active_id SHALL preempt -> START next cycle for that source; preempted source is dropped, not resumed.
REQ-020 PLAY: a request for active_id itself SHALL be discarded (pending[active_id] cleared).
REQ-021 Lower-priority pending flags SHALL be retained through PLAY and GAP.
REQ-022 GAP: lasts GAP_MS ms ticks, audio silent; then pending -> START (winner), else -> IDLE.
REQ-023 audio_out SHALL be registered: square_in[active_id] in PLAY with mute low, else 0; 1-cycle latency.
REQ-024 ms tick SHALL pulse once every CLK_FREQ_per_ms cycles, counter width $clog2(CLK_FREQ_per_ms).
REQ-025 remaining_ms SHALL be 16 bits unsigned; DUR_MS entries SHALL be nonzero, range 1..65535.
REQ-026 trig_n SHALL be all ones outside START.

Reset
REQ-027 On reset: state IDLE, pending 0, trig_n all ones, audio_out 0, busy 0, active_id 0, remaining_ms 0, tick counter 0.
REQ-028 Reset mid-PLAY SHALL silence audio_out in the same cycle (async) and drop all pending requests.

Structure
REQ-029 Package sound_pkg SHALL hold the state enum, DUR_MS array per source (default 50, 150, 500, 1500 ms) and GAP_MS default.
REQ-030 Sub-module ms_ticker SHALL generate the ms tick with a synchronous restart input driven from START.

Verification (CLK_FREQ_per_ms=10, defaults otherwise)
REQ-031 req[0] pulse at cycle 0 -> trig_n[0]=0 in exactly one cycle, PLAY 500 cycles, GAP 200 cycles, busy low after, audio_out follows square_in[0] with 1-cycle lag.
REQ-032 req[1] then req[3] 100 cycles later -> trig_n[3] pulse, active_id=3, source 1 never resumes.
REQ-033 req[2] during PLAY of source 3 -> source 2 starts after source 3's 20 ms gap.
REQ-034 req[1] repeated during source 1 PLAY -> no retrigger, single 150 ms play.
REQ-035 mute high during PLAY -> audio_out 0, timing of GAP/IDLE unchanged.
REQ-036 reset asserted mid-PLAY with req[0] pending -> all outputs at reset values, IDLE after release, no playback.
